read_return_sched: RTL

- Sequences all writes into the read-data buffer (data_buffer) so that data and TID enter in request order.
- Accepts read requests from the command path. Each request is either a RAW hit, with forwarded write data captured at request time, or a DRAM read.
- Keeps an in-order pending queue and stages DRAM return beats.
- Drives dram_strobe/raw_strobe/tid_strobe/mux_data/tid_pop, and throttles requests with credits matched to the buffer depth.

---
 rtl/read_return_sched_pkg.sv | 29 ++
 rtl/rrs_ret_fifo.sv | 65 ++++++
 rtl/read_return_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/read_return_sched_pkg.sv
`default_nettype none
// =============================================================================
// Module  : read_return_sched_pkg
// Brief   : Shared types for the read-return scheduler (queue entry, head FSM).
// Revision: 1.0 - initial release
// =============================================================================
package read_return_sched_pkg;

    localparam int c_DATA_SIZE = 64;
    localparam int c_TID_SIZE  = 2;

    typedef struct packed {
        logic [c_TID_SIZE-1:0]  tid;
        logic                   raw;
        logic [c_DATA_SIZE-1:0] data;
    } pend_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HEAD_RAW  = 2'd1,
        HEAD_DRAM = 2'd2
    } rrs_state_t;

    function automatic rrs_state_t head_state(input logic raw);
        return raw ? HEAD_RAW : HEAD_DRAM;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rrs_ret_fifo.sv
`default_nettype none
// =============================================================================
// Module  : rrs_ret_fifo
// Brief   : Synchronous FIFO staging DRAM return beats (power-of-two depth).
// Revision: 1.0 - initial release
// =============================================================================
module rrs_ret_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [LOG2_DEPTH:0]   count_o
);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic                  w_push, w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (LOG2_DEPTH+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign w_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only safe when the same cycle frees a slot.
    assign w_push = push_i && (!full_o || w_pop);

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + (LOG2_DEPTH+1)'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - (LOG2_DEPTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + LOG2_DEPTH'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + LOG2_DEPTH'(1);
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/read_return_sched.sv
`default_nettype none
// =============================================================================
// Module  : read_return_sched
// Brief   : In-order read-return scheduler feeding data_buffer (RAW / DRAM).
//           Optional rd_stall_cnt output enabled by `define RRS_STALL_CNT_EN.
// Revision: 1.0 - initial release
// =============================================================================
module read_return_sched
    import read_return_sched_pkg::*;
#(
    parameter int DATA_SIZE  = c_DATA_SIZE,
    parameter int TID_SIZE   = c_TID_SIZE,
    parameter int PEND_DEPTH = 8,
    parameter int LOG2_PEND  = 3,
    parameter int BUF_DEPTH  = 64,
    parameter int LOG2_BUF   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req,
    input  logic [TID_SIZE-1:0]  rd_tid,
    input  logic                 rd_raw_hit,
    input  logic [DATA_SIZE-1:0] raw_data,
    output logic                 rd_ready,
    input  logic                 dram_rvalid,
    input  logic [DATA_SIZE-1:0] dram_rdata,
    input  logic                 buf_pop,
    output logic                 dram_strobe,
    output logic                 raw_strobe,
    output logic                 tid_strobe,
    output logic [TID_SIZE-1:0]  tid_pop,
    output logic [DATA_SIZE-1:0] mux_data,
`ifdef RRS_STALL_CNT_EN
    output logic [15:0]          rd_stall_cnt,
`endif
    output logic                 err_unexp
);

    localparam logic [LOG2_PEND:0] c_PEND_FULL = (LOG2_PEND+1)'(PEND_DEPTH);
    localparam logic [LOG2_BUF:0]  c_BUF_FULL  = (LOG2_BUF+1)'(BUF_DEPTH);

    pend_entry_t          q_mem_q [PEND_DEPTH];
    logic [LOG2_PEND-1:0] wr_ptr_q, rd_ptr_q, w_next_rd_ptr;
    logic [LOG2_PEND:0]   count_q, count_d, w_remaining;
    logic [LOG2_PEND:0]   dram_out_q, dram_out_d;
    logic [LOG2_BUF:0]    credits_q, credits_d;
    rrs_state_t           state_q, state_d;

    logic                 dram_strobe_q, raw_strobe_q, tid_strobe_q, err_q;
    logic [TID_SIZE-1:0]  tid_pop_q;
    logic [DATA_SIZE-1:0] mux_data_q;

    logic                 w_accept, w_emit_raw, w_emit_dram, w_deq;
    pend_entry_t          w_new_entry, w_head;
    logic                 w_fifo_push, w_fifo_empty, w_fifo_full;
    logic [DATA_SIZE-1:0] w_fifo_dout;
    logic [LOG2_PEND:0]   w_fifo_count;
    logic                 w_unused;

    assign rd_ready = (count_q < c_PEND_FULL) && (credits_q != '0);
    assign w_accept = rd_req && rd_ready;

    assign w_new_entry.tid  = rd_tid;
    assign w_new_entry.raw  = rd_raw_hit;
    assign w_new_entry.data = rd_raw_hit ? raw_data : '0;
    assign w_head           = q_mem_q[rd_ptr_q];

    assign w_fifo_push = dram_rvalid && (dram_out_q != '0);
    assign w_unused    = ^{w_fifo_full, w_fifo_count};

    rrs_ret_fifo #(
        .WIDTH      (DATA_SIZE),
        .DEPTH      (PEND_DEPTH),
        .LOG2_DEPTH (LOG2_PEND)
    ) u_ret_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_fifo_push),
        .din_i   (dram_rdata),
        .pop_i   (w_emit_dram),
        .dout_o  (w_fifo_dout),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full),
        .count_o (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // State tracks the head as it will be after this edge, so a freshly
    // enqueued RAW entry is emitted on the very next edge.
    always_comb begin
        state_d     = IDLE;
        w_emit_raw  = 1'b0;
        w_emit_dram = 1'b0;
        case (state_q)
            HEAD_RAW:  w_emit_raw  = 1'b1;
            HEAD_DRAM: w_emit_dram = !w_fifo_empty;
            default:   ;
        endcase
        w_deq         = w_emit_raw || w_emit_dram;
        w_remaining   = count_q - (LOG2_PEND+1)'(w_deq);
        w_next_rd_ptr = rd_ptr_q + LOG2_PEND'(w_deq);
        if (w_remaining != '0) begin
            state_d = head_state(q_mem_q[w_next_rd_ptr].raw);
        end else if (w_accept) begin
            state_d = head_state(rd_raw_hit);
        end
    end

    always_comb begin
        count_d = count_q + (LOG2_PEND+1)'(w_accept) - (LOG2_PEND+1)'(w_deq);

        credits_d = credits_q;
        if (w_accept && !buf_pop) begin
            credits_d = credits_q - (LOG2_BUF+1)'(1);
        end else if (!w_accept && buf_pop && (credits_q != c_BUF_FULL)) begin
            credits_d = credits_q + (LOG2_BUF+1)'(1);
        end

        dram_out_d = dram_out_q
                   + (LOG2_PEND+1)'(w_accept && !rd_raw_hit)
                   - (LOG2_PEND+1)'(w_emit_dram);
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            q_mem_q[wr_ptr_q] <= w_new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            credits_q     <= c_BUF_FULL;
            dram_out_q    <= '0;
            err_q         <= 1'b0;
            dram_strobe_q <= 1'b0;
            raw_strobe_q  <= 1'b0;
            tid_strobe_q  <= 1'b0;
            tid_pop_q     <= '0;
            mux_data_q    <= '0;
        end else begin
            if (w_accept) wr_ptr_q <= wr_ptr_q + LOG2_PEND'(1);
            rd_ptr_q   <= w_next_rd_ptr;
            count_q    <= count_d;
            credits_q  <= credits_d;
            dram_out_q <= dram_out_d;
            if (dram_rvalid && (dram_out_q == '0)) begin
                err_q <= 1'b1;
            end
            dram_strobe_q <= w_emit_dram;
            raw_strobe_q  <= w_emit_raw;
            tid_strobe_q  <= w_deq;
            if (w_deq) begin
                tid_pop_q  <= w_head.tid;
                mux_data_q <= w_emit_raw ? w_head.data : w_fifo_dout;
            end
        end
    end

`ifdef RRS_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (rd_req && !rd_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign rd_stall_cnt = stall_cnt_q;
`endif

    assign dram_strobe = dram_strobe_q;
    assign raw_strobe  = raw_strobe_q;
    assign tid_strobe  = tid_strobe_q;
    assign tid_pop     = tid_pop_q;
    assign mux_data    = mux_data_q;
    assign err_unexp   = err_q;

endmodule
`default_nettype wire
